branch_pred_unit: RTL

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

---
 rtl/branch_pred_unit_pkg.sv | 70 +++++++
 rtl/bpu_table.sv | 78 +++++++
 rtl/branch_pred_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/branch_pred_unit_pkg.sv
// Shared opcode/funct constants, counter encodings and decode helpers for the
// branch prediction unit and its table.
package branch_pred_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    typedef enum logic [2:0] {
        CF_NONE,
        CF_BEQ,
        CF_BNE,
        CF_J,
        CF_JAL,
        CF_JR,
        CF_JALR
    } cf_kind_t;

    typedef enum logic [1:0] {
        WR_BR_TAKEN,
        WR_BR_NOT,
        WR_JUMP
    } wr_op_t;

    function automatic cf_kind_t decode_cf(input logic [5:0] op, input logic [5:0] funct);
        cf_kind_t k;
        k = CF_NONE;
        case (op)
            OP_BEQ:   k = CF_BEQ;
            OP_BNE:   k = CF_BNE;
            OP_J:     k = CF_J;
            OP_JAL:   k = CF_JAL;
            OP_RTYPE: begin
                if (funct == FN_JR)
                    k = CF_JR;
                else if (funct == FN_JALR)
                    k = CF_JALR;
            end
            default:  k = CF_NONE;
        endcase
        return k;
    endfunction

    // Two-bit saturating step towards taken or not-taken.
    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != CTR_ST)
                n = ctr_t'(2'(c) + 2'd1);
        end else begin
            if (c != CTR_SNT)
                n = ctr_t'(2'(c) - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped prediction table: one combinational read port and one
// synchronous read-modify-write update port.
module bpu_table
    import branch_pred_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output ctr_t              rd_ctr,
    output logic [DATA_W-1:0] rd_target,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_target,
    input  wr_op_t            wr_op
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic              valid_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    ctr_t              ctr_q    [DEPTH];
    logic [DATA_W-1:0] target_q [DEPTH];

    logic wr_hit;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Hit/miss is resolved here against the stored tag so the read port stays free for fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= CTR_WNT;
                target_q[i] <= '0;
            end
        end else if (wr_en) begin
            case (wr_op)
                WR_BR_TAKEN: begin
                    if (wr_hit) begin
                        ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], 1'b1);
                    end else begin
                        valid_q[wr_idx] <= 1'b1;
                        tag_q[wr_idx]   <= wr_tag;
                        ctr_q[wr_idx]   <= CTR_WT;
                    end
                    target_q[wr_idx] <= wr_target;
                end
                WR_BR_NOT: begin
                    if (wr_hit) begin
                        ctr_q[wr_idx]    <= ctr_step(ctr_q[wr_idx], 1'b0);
                        target_q[wr_idx] <= wr_target;
                    end
                end
                WR_JUMP: begin
                    valid_q[wr_idx]  <= 1'b1;
                    tag_q[wr_idx]    <= wr_tag;
                    ctr_q[wr_idx]    <= CTR_ST;
                    target_q[wr_idx] <= wr_target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Fetch-side branch prediction lookup plus resolve-stage branch/jump
// evaluation, misprediction redirect, link control and table training.
module branch_pred_unit
    import branch_pred_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic [DATA_W-1:0] i_if_pc,
    output logic              o_pred_taken,
    output logic [DATA_W-1:0] o_pred_target,
    input  logic              i_valid,
    input  logic [5:0]        i_op,
    input  logic [5:0]        i_funct,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_sign_ext,
    input  logic [DATA_W-1:0] i_jump_address,
    input  logic [DATA_W-1:0] i_rs_reg,
    input  logic [DATA_W-1:0] i_rt_reg,
    input  logic              i_pred_taken,
    input  logic [DATA_W-1:0] i_pred_target,
    output logic              os_redirect,
    output logic [DATA_W-1:0] o_redirect_addr,
    output logic              os_write_pc,
    output logic              os_select_addr_reg,
    output logic [DATA_W-1:0] o_pc_to_reg,
    output logic [31:0]       o_mispred_cnt
);

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    ctr_t              rd_ctr;
    logic [DATA_W-1:0] rd_target;
    logic              lk_taken;

    cf_kind_t          kind;
    logic              act_taken;
    logic [DATA_W-1:0] act_target;

    logic [DATA_W-1:0] upd_pc;
    logic              wr_en;
    wr_op_t            wr_op;

    logic [31:0]       cnt_q;
    logic              unused_bits;

    bpu_table #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (i_if_pc[IDX_W-1:0]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_ctr    (rd_ctr),
        .rd_target (rd_target),
        .wr_en     (wr_en),
        .wr_idx    (upd_pc[IDX_W-1:0]),
        .wr_tag    (upd_pc[IDX_W+TAG_W-1:IDX_W]),
        .wr_target (act_target),
        .wr_op     (wr_op)
    );

    assign lk_taken = rd_valid && (rd_tag == i_if_pc[IDX_W+TAG_W-1:IDX_W]) && rd_ctr[1];

    always_comb begin
        o_pred_taken  = 1'b0;
        o_pred_target = '0;
        if (rst && lk_taken) begin
            o_pred_taken  = 1'b1;
            o_pred_target = rd_target;
        end
    end

    always_comb begin
        kind       = decode_cf(i_op, i_funct);
        act_taken  = 1'b0;
        act_target = '0;
        case (kind)
            CF_BEQ: begin
                act_taken  = (i_rs_reg == i_rt_reg);
                act_target = i_pc + i_sign_ext;
            end
            CF_BNE: begin
                act_taken  = (i_rs_reg != i_rt_reg);
                act_target = i_pc + i_sign_ext;
            end
            CF_J, CF_JAL: begin
                act_taken  = 1'b1;
                act_target = i_jump_address;
            end
            CF_JR, CF_JALR: begin
                act_taken  = 1'b1;
                act_target = i_rs_reg;
            end
            default: ;
        endcase
    end

    // A bubble carrying a taken prediction still sent fetch astray, so it redirects back to i_pc.
    always_comb begin
        os_redirect        = 1'b0;
        o_redirect_addr    = '0;
        os_write_pc        = 1'b0;
        os_select_addr_reg = 1'b0;
        o_pc_to_reg        = '0;
        if (rst) begin
            if (i_valid) begin
                os_redirect     = (act_taken != i_pred_taken) ||
                                  (act_taken && (act_target != i_pred_target));
                o_redirect_addr = act_taken ? act_target : i_pc;
                if (kind == CF_JAL) begin
                    os_write_pc        = 1'b1;
                    os_select_addr_reg = 1'b1;
                    o_pc_to_reg        = i_pc;
                end else if (kind == CF_JALR) begin
                    os_write_pc = 1'b1;
                    o_pc_to_reg = i_pc;
                end
            end else if (i_pred_taken) begin
                os_redirect     = 1'b1;
                o_redirect_addr = i_pc;
            end
        end
    end

    // i_pc is one word past the resolving instruction; the table is keyed on its own PC.
    assign upd_pc = i_pc - DATA_W'(1);

    always_comb begin
        wr_en = 1'b0;
        wr_op = WR_BR_NOT;
        if (rst && i_valid && !i_stall) begin
            case (kind)
                CF_BEQ, CF_BNE: begin
                    wr_en = 1'b1;
                    wr_op = act_taken ? WR_BR_TAKEN : WR_BR_NOT;
                end
                CF_J, CF_JAL: begin
                    wr_en = 1'b1;
                    wr_op = WR_JUMP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (os_redirect && !i_stall && (cnt_q != '1))
            cnt_q <= cnt_q + 32'd1;
    end

    assign o_mispred_cnt = cnt_q;

    assign unused_bits = ^{i_if_pc, upd_pc, rd_ctr};

endmodule
